// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame
// constants and the baud-counter terminal value helper.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int unsigned DEFAULT_BAUD_DIV = 32'd434;
   localparam int unsigned DATA_BITS        = 32'd8;
   localparam int unsigned FRAME_BITS       = 32'd10;

   // Index of the last data bit inside a frame (bit counter is 3 bits wide).
   localparam logic [2:0]  LAST_BIT_IDX     = 3'(DATA_BITS - 32'd1);

   // Terminal value of the 16-bit baud counter for a given divider.
   function automatic logic [15:0] baud_last(input int unsigned div);
      return 16'(div - 32'd1);
   endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous circular FIFO. Head byte is presented combinationally
// on dout; a byte pushed at one edge becomes poppable from the next edge on.
module sync_fifo_byte
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [7:0]         din,
   output logic [7:0]         dout,
   output logic [FIFO_AW:0]   count,
   output logic               full,
   output logic               empty
);

   localparam int unsigned       DEPTH     = 32'd1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]  CNT_ZERO  = {(FIFO_AW+1){1'b0}};

   logic [7:0]          mem_r [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_r;
   logic [FIFO_AW-1:0]  rd_ptr_r;
   logic [FIFO_AW:0]    count_r;
   logic                push_ok_s;
   logic                pop_ok_s;

   // Qualify requests so the buffer can never over- or under-run.
   always_comb begin
      push_ok_s = push && (count_r != DEPTH_CNT);
      pop_ok_s  = pop && (count_r != CNT_ZERO);
   end

   // Storage array; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; push and pop together keep count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + FIFO_AW'(32'd1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(32'd1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (FIFO_AW+1)'(32'd1);
            2'b01:   count_r <= count_r - (FIFO_AW+1)'(32'd1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = (count_r == DEPTH_CNT);
   assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Rising edges of the level-style write strobe
// enqueue one byte each; frames are shifted out LSB first, back to back when
// the buffer still holds data at the end of a stop bit.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_in,
   input  logic       tx_write,
   output logic       txd,
   output logic       tx_busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam logic [15:0]      BAUD_LAST = baud_last(BAUD_DIV);
   localparam logic [FIFO_AW:0] CNT_ZERO  = {(FIFO_AW+1){1'b0}};

   logic             wr_d_r;
   logic             overflow_r;
   tx_state_t        state_r;
   tx_state_t        state_s;
   logic [15:0]      cnt_r;
   logic [15:0]      cnt_s;
   logic [2:0]       bit_idx_r;
   logic [2:0]       bit_idx_s;
   logic [7:0]       shift_r;
   logic [7:0]       shift_s;
   logic             txd_r;
   logic             txd_s;
   logic             rise_s;
   logic             push_s;
   logic             pop_s;
   logic [7:0]       fifo_dout_s;
   logic [FIFO_AW:0] fifo_count_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;

   sync_fifo_byte #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (tx_in),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Write strobe edge detect; a held strobe yields a single accept.
   always_comb begin
      rise_s = tx_write && !wr_d_r;
      push_s = rise_s && !fifo_full_s;
   end

   // Strobe history and overflow pulse, judged on the pre-edge fill level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_d_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_d_r     <= tx_write;
         overflow_r <= rise_s && fifo_full_s;
      end
   end

   // Frame sequencer next-state: baud timing, bit shifting and FIFO pops.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      txd_s     = txd_r;
      pop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_s = 16'd0;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_s = fifo_dout_s;
               txd_s   = 1'b0;
               state_s = ST_START;
            end else begin
               txd_s   = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_r == BAUD_LAST) begin
               cnt_s     = 16'd0;
               txd_s     = shift_r[0];
               bit_idx_s = 3'd0;
               state_s   = ST_DATA;
            end else begin
               cnt_s     = cnt_r + 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt_r == BAUD_LAST) begin
               cnt_s = 16'd0;
               if (bit_idx_r == LAST_BIT_IDX) begin
                  txd_s   = 1'b1;
                  state_s = ST_STOP;
               end else begin
                  shift_s   = {1'b0, shift_r[7:1]};
                  txd_s     = shift_r[1];
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         ST_STOP: begin
            if (cnt_r == BAUD_LAST) begin
               cnt_s = 16'd0;
               if (!fifo_empty_s) begin
                  // Next frame starts without an idle bit in between.
                  pop_s   = 1'b1;
                  shift_s = fifo_dout_s;
                  txd_s   = 1'b0;
                  state_s = ST_START;
               end else begin
                  txd_s   = 1'b1;
                  state_s = ST_IDLE;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         default: begin
            cnt_s   = 16'd0;
            txd_s   = 1'b1;
            state_s = ST_IDLE;
         end
      endcase
   end

   // Frame sequencer registers; reset abandons any frame and idles the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 16'd0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'd0;
         txd_r     <= 1'b1;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_idx_r <= bit_idx_s;
         shift_r   <= shift_s;
         txd_r     <= txd_s;
      end
   end

   assign txd       = txd_r;
   assign tx_busy   = (state_r != ST_IDLE) || (fifo_count_s != CNT_ZERO);
   assign fifo_full = fifo_full_s;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A timeline model schedules every accepted byte
// as a 10-bit frame on the serial line and predicts txd, tx_busy, fifo_full
// and overflow for every clock cycle.
module tb_uart_tx_fifo;

   localparam int BD    = 4;
   localparam int FL    = 10 * BD;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       tx_write = 1'b0;
   logic [7:0] tx_in = 8'h00;
   logic       txd;
   logic       tx_busy;
   logic       fifo_full;
   logic       overflow;

   uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_AW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_in     (tx_in),
      .tx_write  (tx_write),
      .txd       (txd),
      .tx_busy   (tx_busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit wr_prev = 1'b0;

   // Model: one entry per accepted byte, with the edge at which its start bit begins.
   int         f_start[$];
   logic [7:0] f_byte[$];
   logic exp_txd, exp_busy, exp_full, exp_ovf;

   // Bytes accepted but not yet popped before edge k.
   function automatic int pending_at(int k);
      int n = 0;
      foreach (f_start[i]) if (f_start[i] >= k) n++;
      return n;
   endfunction

   function automatic int line_free();
      if (f_start.size() == 0) return 0;
      return f_start[f_start.size()-1] + FL;
   endfunction

   function automatic logic model_txd(int k);
      foreach (f_start[i]) begin
         if (f_start[i] <= k && k < f_start[i] + FL) begin
            int bp = (k - f_start[i]) / BD;
            if (bp == 0) return 1'b0;
            if (bp == 9) return 1'b1;
            return f_byte[i][bp-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic model_busy(int k);
      foreach (f_start[i]) if (f_start[i] + FL > k) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      f_start.delete();
      f_byte.delete();
      wr_prev = 1'b0;
   endtask

   // Advance one clock edge, apply the acceptance rules and predict outputs.
   task automatic step();
      bit rise;
      int s;
      @(posedge clk);
      cyc++;
      rise    = tx_write && !wr_prev;
      wr_prev = tx_write;
      exp_ovf = 1'b0;
      if (rise) begin
         if (pending_at(cyc) < DEPTH) begin
            s = (cyc + 1 > line_free()) ? cyc + 1 : line_free();
            f_start.push_back(s);
            f_byte.push_back(tx_in);
         end else begin
            exp_ovf = 1'b1;
         end
      end
      exp_txd  = model_txd(cyc);
      exp_busy = model_busy(cyc);
      exp_full = (pending_at(cyc + 1) == DEPTH);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (txd !== 1'b1)       begin n_fail++; $display("FAIL reset_txd got=%b exp=1", txd); end
      n_tests++; if (tx_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
      n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
      n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         n_tests++; if (txd !== exp_txd)   begin n_fail++; $display("FAIL idle_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy) begin n_fail++; $display("FAIL idle_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 50; i++) begin
         tx_write = (i == 0);
         tx_in    = 8'hA5;
         step();
         n_tests++; if (txd !== exp_txd)       begin n_fail++; $display("FAIL single_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy)  begin n_fail++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
         n_tests++; if (fifo_full !== exp_full) begin n_fail++; $display("FAIL single_full cyc=%0d got=%b exp=%b", cyc, fifo_full, exp_full); end
         n_tests++; if (overflow !== exp_ovf)  begin n_fail++; $display("FAIL single_ovf cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
      end
   endtask

   task automatic test_held_strobe();
      for (int i = 0; i < 210; i++) begin
         tx_write = (i < 200);
         tx_in    = 8'h01;
         step();
         n_tests++; if (txd !== exp_txd)      begin n_fail++; $display("FAIL held_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy) begin n_fail++; $display("FAIL held_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
         n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL held_ovf cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      for (int i = 0; i < 130; i++) begin
         tx_write = (i == 0 || i == 2 || i == 4);
         if (i <= 4) tx_in = bytes[i/2];
         step();
         n_tests++; if (txd !== exp_txd)      begin n_fail++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
      end
   endtask

   task automatic test_overflow();
      int ovf_seen = 0;
      int full_seen = 0;
      for (int i = 0; i < 760; i++) begin
         tx_write = (i < 36) && (i % 2 == 0);
         tx_in    = 8'($urandom);
         step();
         if (overflow === 1'b1) ovf_seen++;
         if (fifo_full === 1'b1) full_seen++;
         n_tests++; if (txd !== exp_txd)        begin n_fail++; $display("FAIL ovf_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy)   begin n_fail++; $display("FAIL ovf_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
         n_tests++; if (fifo_full !== exp_full) begin n_fail++; $display("FAIL ovf_full cyc=%0d got=%b exp=%b", cyc, fifo_full, exp_full); end
         n_tests++; if (overflow !== exp_ovf)   begin n_fail++; $display("FAIL ovf_pulse cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
      end
      n_tests++; if (ovf_seen != 1) begin n_fail++; $display("FAIL ovf_count got=%0d exp=1", ovf_seen); end
      n_tests++; if (full_seen == 0) begin n_fail++; $display("FAIL ovf_full_seen got=%0d exp=nonzero", full_seen); end
   endtask

   task automatic test_simul_push_pop();
      for (int i = 0; i < 130; i++) begin
         tx_write = (i == 0 || i == 2 || i == 41);
         tx_in    = 8'($urandom);
         step();
         n_tests++; if (txd !== exp_txd)        begin n_fail++; $display("FAIL simul_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy)   begin n_fail++; $display("FAIL simul_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
         n_tests++; if (overflow !== exp_ovf)   begin n_fail++; $display("FAIL simul_ovf cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
      end
   endtask

   task automatic test_random();
      int hold = 0;
      int gap  = 0;
      for (int i = 0; i < 1520; i++) begin
         if (hold > 0) begin
            tx_write = 1'b1; hold--;
         end else if (gap > 0 || i > 800) begin
            tx_write = 1'b0; if (gap > 0) gap--;
         end else begin
            tx_write = 1'b1;
            tx_in    = 8'($urandom);
            hold     = $urandom_range(0, 3);
            gap      = $urandom_range(1, 25);
         end
         step();
         n_tests++; if (txd !== exp_txd)        begin n_fail++; $display("FAIL rand_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy)   begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
         n_tests++; if (fifo_full !== exp_full) begin n_fail++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, fifo_full, exp_full); end
         n_tests++; if (overflow !== exp_ovf)   begin n_fail++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf); end
      end
   endtask

   task automatic test_reset_mid_frame();
      // Edge 18 after the accept lands in the middle of data bit 3.
      for (int i = 0; i < 19; i++) begin
         tx_write = (i == 0);
         tx_in    = 8'($urandom);
         step();
         n_tests++; if (txd !== exp_txd) begin n_fail++; $display("FAIL mid_pre_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
      end
      rst_n = 1'b0;
      #1;
      n_tests++; if (txd !== 1'b1)     begin n_fail++; $display("FAIL mid_rst_txd got=%b exp=1", txd); end
      n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", tx_busy); end
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 110; i++) begin
         tx_write = (i == 60);
         tx_in    = 8'($urandom);
         step();
         n_tests++; if (txd !== exp_txd)      begin n_fail++; $display("FAIL mid_post_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd); end
         n_tests++; if (tx_busy !== exp_busy) begin n_fail++; $display("FAIL mid_post_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, exp_busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_held_strobe();
      test_back_to_back();
      test_overflow();
      test_simul_push_pop();
      test_random();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmit stage directly downstream of the command controller.
- Consumes the controller's byte output `tx_in` and its level-style write strobe `tx_write`.
- Buffers accepted bytes in a small FIFO and shifts them out on `txd` as 8N1 UART frames, LSB first.
- Decouples the controller's timed status writes (and receiver pass-through bursts) from the serial line rate.

Parameters:
- BAUD_DIV, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_in  in  8  byte to transmit; sampled on the accepting edge.
- tx_write  in  1  write request, level-style; a byte is accepted on its rising edge only.
- txd  out  1  serial line; idles high.
- tx_busy  out  1  high while FIFO is non-empty or a frame is in flight.
- fifo_full  out  1  FIFO holds 2**FIFO_AW bytes.
- overflow  out  1  1-cycle pulse when a write edge is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - txd=1, tx_busy=0, fifo_full=0, overflow=0.
  - Internal write-edge register=0; FIFO pointers and count=0; FSM=IDLE; baud counter=0; bit index=0.
- Write detect:
  - Register `wr_d` <= `tx_write` each cycle.
  - Accept when `tx_write && !wr_d` and count < depth, judged on the pre-edge count.
  - `tx_in` is written at that edge.
  - Holding `tx_write` high for N cycles enqueues exactly one byte. Consecutive bytes need `tx_write` low for at least 1 cycle between them.
- Overflow: a rising edge while count == depth drops the byte and pulses `overflow` high in the next cycle only. FIFO contents are unchanged.
- FIFO:
  - Circular buffer with read/write pointers of width FIFO_AW, wrapping modulo depth, plus a count of width FIFO_AW+1.
  - Simultaneous push and pop at the same edge leaves count unchanged.
  - No push-to-pop bypass: a byte pushed at edge E can be popped at E+1 at the earliest.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count != 0, pop the head into the shift register, txd<=0, baud counter<=0, go to START. Otherwise txd stays 1.
  - START: txd=0 for BAUD_DIV cycles. When the baud counter reaches BAUD_DIV-1: counter<=0, txd<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit lasts BAUD_DIV cycles. At counter==BAUD_DIV-1, shift right and increment the bit index. After bit index 7 completes, txd<=1 and go to STOP.
  - STOP: txd=1 for BAUD_DIV cycles. At the end, if count != 0, pop and enter START directly (txd<=0), giving back-to-back frames with zero gap. Otherwise go to IDLE.
- Frame timing:
  - Frame length is exactly 10*BAUD_DIV cycles.
  - Latency from the accepting edge E0 (FIFO previously empty and FSM in IDLE) to txd falling: txd goes low at edge E0+1.
- Output definitions:
  - tx_busy = (state != IDLE) || (count != 0), combinational from registers.
  - fifo_full = (count == depth).
- Widths: the baud counter is 16 bits and compares against BAUD_DIV-1; no wrap beyond that value.
- Reset mid-frame: txd returns to 1 asynchronously, the FIFO is emptied, and the partial frame is abandoned.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3 (2-bit).
  - DEFAULT_BAUD_DIV=434.
  - Frame constants: DATA_BITS=8, frame length 10.
- One natural sub-module, `sync_fifo_byte`: parameterised by FIFO_AW, with push/pop/din/dout/count/full/empty ports.
- The top level holds edge detect, overflow, FSM and baud counter.

Test Plan (BAUD_DIV=4 for the bench):
- Single byte: `tx_write` pulse with `tx_in`=0xA5 → txd low at accept+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. tx_busy falls after 40 cycles.
- Held strobe: `tx_write` high for 200 cycles with `tx_in`=0x01 → exactly one frame, no second frame.
- Back-to-back: 3 write edges (0x11, 0x22, 0x33) 2 cycles apart → 3 frames with no idle gap, 120 txd cycles total, decoded bytes equal the inputs in order.
- Full/overflow: 17 write edges while the first frame is in flight:
  - 1st byte popped, 16 buffered, fifo_full=1, no overflow pulse.
  - An 18th edge gives overflow=1 for exactly 1 cycle and that byte is never sent.
- Simultaneous push/pop: a write edge on the same cycle STOP ends with count=1 → count stays 1, the next frame starts with no gap, and the pushed byte is transmitted after the popped one.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 → txd=1 immediately, tx_busy=0. After release, no residual frame is emitted until a new write edge arrives.
